mips_cpu: RTL and testbench
===========================

// Module: mips_cpu
// PURPOSE
//  - Simple 16-bit MIPS-style datapath slice: registered ALU, program counter (PC) unit and 4-bit step timer.
//  - Top level of the Simple_MIPS FPGA design; ALU operands and opcode come directly from ports (board switches / bench).
//  - key_ok is the board "step" key; it gates PC and timer advance.
// PARAMETERS
//  - WORD_SIZE  16  datapath width: ALU operands/result, PC, data_in, offset
//  - OP_SIZE    4   ALU select width
// PORTS
//  - clk            in   1          single system clock, rising edge
//  - rst            in   1          synchronous reset, active-high
//  - key_ok         in   1          step enable for PC and timer (1 = advance)
//  - data_1         in   WORD_SIZE  ALU operand A
//  - data_2         in   WORD_SIZE  ALU operand B
//  - sel            in   OP_SIZE    ALU opcode
//  - alu_out        out  WORD_SIZE  registered ALU result
//  - alu_zero_flag  out  1          registered, 1 when alu_out == 0
//  - timer          out  4          free step counter
//  - data_in        in   WORD_SIZE  PC load value
//  - load_pc        in   1          load PC from data_in
//  - offset         in   WORD_SIZE  signed branch offset, in words
//  - branch         in   1          take relative branch
//  - pc_counter     out  WORD_SIZE  current PC
// BEHAVIOUR
//  - Reset (rst=1 at posedge clk) clears outputs and dominates every other input:
//    - alu_out = 0, alu_zero_flag = 1, timer = 0, pc_counter = 0.
//  - ALU opcodes (sel):
//    - 4'b0101 AND: A & B.
//    - 4'b0110 OR: A | B.
//    - 4'b0111 ADD: A + B.
//    - 4'b1000 SUB: A - B.
//    - 4'b1001 SLT: 1 if signed A < signed B, else 0.
//    - Any other sel code: result 0.
//  - ADD/SUB wrap modulo 2^WORD_SIZE; no carry output.
//  - ALU timing:
//    - Result computed combinationally and registered each clock, independent of key_ok; latency 1 cycle.
//    - alu_zero_flag is registered in the same cycle as alu_out, from the same result.
//  - PC update, only when key_ok=1 (key_ok=0 holds PC); priority load_pc > branch > increment:
//    - load_pc=1: PC <= data_in.
//    - else branch=1: PC <= PC + 1 + offset (offset sign-extended, two's complement, wraps).
//    - else: PC <= PC + 1, wrapping 0xFFFF -> 0x0000.
//  - Simultaneous load_pc and branch: load_pc wins, branch is ignored.
//  - timer: increments by 1 each clock while key_ok=1; wraps 15 -> 0; holds when key_ok=0.
//  - Reset asserted mid-operation takes effect at the next edge; no pending state survives it.
// CONFIGURATION
//  - Macro MIPS_CPU_OVERFLOW_EN.
//  - Defined:
//    - Adds output alu_overflow (1 bit), registered with alu_out; reset value 0.
//    - Set on signed overflow of ADD/SUB; 0 for all other opcodes.
//  - Undefined: port absent; all other behaviour identical.
// STRUCTURE
//  - Package mips_cpu_pkg: WORD_SIZE/OP_SIZE defaults and ALU opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT).
//  - Sub-module mips_alu: purely combinational result / zero / overflow logic.
//  - Registers, PC unit and timer stay in mips_cpu.
// TESTING
//  - Reset: hold rst 2 cycles -> alu_out=0000, alu_zero_flag=1, pc_counter=0000, timer=0.
//  - ALU basics, A=0004, B=0005, result checked one edge after inputs change:
//    - ADD -> 0009; SUB -> FFFF, zero=0; AND -> 0004; OR -> 0005; SLT -> 0001.
//  - ALU edge cases:
//    - SLT A=FFFF, B=0001 -> 0001; SLT A=0005, B=0004 -> 0000.
//    - SUB 0005-0005 -> 0000, zero=1; sel=4'b0000 -> 0000.
//  - PC, key_ok=1:
//    - 3 idle cycles after reset -> 0003.
//    - load_pc with data_in=0100 -> 0100.
//    - branch with offset=FFFE -> 00FF.
//    - load_pc+branch together with data_in=0020 -> 0020.
//  - PC wrap: load_pc 0xFFFF, then one idle cycle -> 0000.
//  - key_ok gating:
//    - key_ok=0 for 5 cycles -> PC and timer unchanged while ALU still updates.
//    - 16 enabled cycles -> timer returns to 0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Purpose : shared sizes and ALU opcode constants for the Simple_MIPS datapath slice.
// Contents: DEF_WORD_SIZE / DEF_OP_SIZE defaults, ALU_* opcode encodings.
// Options : MIPS_CPU_OVERFLOW_EN (used by mips_cpu_if, mips_alu, mips_cpu) adds alu_overflow.
package mips_cpu_pkg;

    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_OP_SIZE   = 4;

    localparam logic [DEF_OP_SIZE-1:0] ALU_AND = 4'b0101;
    localparam logic [DEF_OP_SIZE-1:0] ALU_OR  = 4'b0110;
    localparam logic [DEF_OP_SIZE-1:0] ALU_ADD = 4'b0111;
    localparam logic [DEF_OP_SIZE-1:0] ALU_SUB = 4'b1000;
    localparam logic [DEF_OP_SIZE-1:0] ALU_SLT = 4'b1001;

endpackage

// File: rtl/mips_cpu_if.sv
// Purpose : bundles the ALU operand/result and PC/timer signals of mips_cpu.
// Ports   : master = stimulus side (drives operands, opcode, step/load/branch);
//           slave  = mips_cpu (drives alu_out, alu_zero_flag, timer, pc_counter).
// Options : MIPS_CPU_OVERFLOW_EN adds alu_overflow (slave output).
interface mips_cpu_if #(
    parameter int WORD_SIZE = mips_cpu_pkg::DEF_WORD_SIZE,
    parameter int OP_SIZE   = mips_cpu_pkg::DEF_OP_SIZE
);
    logic                 key_ok;
    logic [WORD_SIZE-1:0] data_1;
    logic [WORD_SIZE-1:0] data_2;
    logic [OP_SIZE-1:0]   sel;
    logic [WORD_SIZE-1:0] alu_out;
    logic                 alu_zero_flag;
    logic [3:0]           timer;
    logic [WORD_SIZE-1:0] data_in;
    logic                 load_pc;
    logic [WORD_SIZE-1:0] offset;
    logic                 branch;
    logic [WORD_SIZE-1:0] pc_counter;
`ifdef MIPS_CPU_OVERFLOW_EN
    logic                 alu_overflow;
`endif

    modport master (
        output key_ok, data_1, data_2, sel, data_in, load_pc, offset, branch,
        input  alu_out, alu_zero_flag, timer, pc_counter
`ifdef MIPS_CPU_OVERFLOW_EN
        , input alu_overflow
`endif
    );

    modport slave (
        input  key_ok, data_1, data_2, sel, data_in, load_pc, offset, branch,
        output alu_out, alu_zero_flag, timer, pc_counter
`ifdef MIPS_CPU_OVERFLOW_EN
        , output alu_overflow
`endif
    );

endinterface

// File: rtl/mips_alu.sv
// Purpose : purely combinational ALU: AND/OR/ADD/SUB/SLT, zero detect, optional signed overflow.
// Ports   : a_i, b_i operands; sel_i opcode; result_o, zero_o; ovf_o (MIPS_CPU_OVERFLOW_EN only).
// Latency : 0 cycles (registered by the caller).
module mips_alu
    import mips_cpu_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int OP_SIZE   = DEF_OP_SIZE
) (
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    input  logic [OP_SIZE-1:0]   sel_i,
    output logic [WORD_SIZE-1:0] result_o,
`ifdef MIPS_CPU_OVERFLOW_EN
    output logic                 ovf_o,
`endif
    output logic                 zero_o
);

    localparam int MSB = WORD_SIZE - 1;

    logic [WORD_SIZE-1:0] sum;
    logic [WORD_SIZE-1:0] diff;
    logic                 lt;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign lt   = $signed(a_i) < $signed(b_i);

    always_comb begin
        result_o = '0;
        case (sel_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = sum;
            ALU_SUB: result_o = diff;
            ALU_SLT: result_o = {{(WORD_SIZE-1){1'b0}}, lt};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

`ifdef MIPS_CPU_OVERFLOW_EN
    // Signed overflow: ADD overflows when like-signed operands give an opposite-signed sum;
    // SUB overflows when differently-signed operands give a result whose sign differs from A.
    always_comb begin
        ovf_o = 1'b0;
        case (sel_i)
            ALU_ADD: ovf_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB]  != a_i[MSB]);
            ALU_SUB: ovf_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            default: ovf_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/mips_cpu.sv
// Purpose : Simple_MIPS top: registered ALU result/zero flag, step-gated PC unit and 4-bit step timer.
// Ports   : clk, rst (synchronous, active-high); bus (mips_cpu_if.slave) carries operands, opcode,
//           key_ok, PC load/branch controls and the alu_out/alu_zero_flag/timer/pc_counter outputs.
// Options : MIPS_CPU_OVERFLOW_EN adds registered alu_overflow (reset 0). ALU latency 1 cycle.
module mips_cpu
    import mips_cpu_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int OP_SIZE   = DEF_OP_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    mips_cpu_if.slave  bus
);

    logic [WORD_SIZE-1:0] alu_res;
    logic                 alu_zero;
`ifdef MIPS_CPU_OVERFLOW_EN
    logic                 alu_ovf;
    logic                 ovf_q;
`endif

    logic [WORD_SIZE-1:0] alu_q;
    logic                 zero_q;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [3:0]           timer_q, timer_d;

    mips_alu #(
        .WORD_SIZE (WORD_SIZE),
        .OP_SIZE   (OP_SIZE)
    ) u_alu (
        .a_i      (bus.data_1),
        .b_i      (bus.data_2),
        .sel_i    (bus.sel),
        .result_o (alu_res),
`ifdef MIPS_CPU_OVERFLOW_EN
        .ovf_o    (alu_ovf),
`endif
        .zero_o   (alu_zero)
    );

    // PC next state: load beats branch beats increment; all arithmetic wraps at WORD_SIZE.
    always_comb begin
        pc_d    = pc_q;
        timer_d = timer_q;
        if (bus.key_ok) begin
            timer_d = timer_q + 4'd1;
            if (bus.load_pc)
                pc_d = bus.data_in;
            else if (bus.branch)
                pc_d = pc_q + WORD_SIZE'(1) + bus.offset;
            else
                pc_d = pc_q + WORD_SIZE'(1);
        end
    end

    // ALU registers load every cycle regardless of key_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q   <= '0;
            zero_q  <= 1'b1;
            pc_q    <= '0;
            timer_q <= '0;
`ifdef MIPS_CPU_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            alu_q   <= alu_res;
            zero_q  <= alu_zero;
            pc_q    <= pc_d;
            timer_q <= timer_d;
`ifdef MIPS_CPU_OVERFLOW_EN
            ovf_q   <= alu_ovf;
`endif
        end
    end

    assign bus.alu_out       = alu_q;
    assign bus.alu_zero_flag = zero_q;
    assign bus.pc_counter    = pc_q;
    assign bus.timer         = timer_q;
`ifdef MIPS_CPU_OVERFLOW_EN
    assign bus.alu_overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_mips_cpu.sv
// Purpose : directed self-checking bench for mips_cpu (ALU ops/edges, PC load/branch/wrap, key_ok gating, timer wrap).
// Ports   : none; drives mips_cpu through a mips_cpu_if instance, clock period 10.
// Options : MIPS_CPU_OVERFLOW_EN also checks alu_overflow.
module tb_mips_cpu;
    import mips_cpu_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mips_cpu_if #(.WORD_SIZE(16), .OP_SIZE(4)) bus ();

    mips_cpu #(.WORD_SIZE(16), .OP_SIZE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.sel    = op;
        bus.data_1 = a;
        bus.data_2 = b;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst          = 1'b1;
        bus.key_ok   = 1'b0;
        bus.data_1   = 16'h0000;
        bus.data_2   = 16'h0000;
        bus.sel      = 4'b0000;
        bus.data_in  = 16'h0000;
        bus.load_pc  = 1'b0;
        bus.offset   = 16'h0000;
        bus.branch   = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        check("rst_alu",   bus.alu_out,       16'h0000);
        check("rst_zero",  bus.alu_zero_flag, 1'b1);
        check("rst_pc",    bus.pc_counter,    16'h0000);
        check("rst_timer", bus.timer,         4'd0);
`ifdef MIPS_CPU_OVERFLOW_EN
        check("rst_ovf",   bus.alu_overflow,  1'b0);
`endif
        rst = 1'b0;

        // ALU with key_ok=0: ALU still updates, PC/timer hold
        alu_op(ALU_ADD, 16'h0004, 16'h0005);
        check("add",       bus.alu_out,       16'h0009);
        check("add_zero",  bus.alu_zero_flag, 1'b0);
        alu_op(ALU_SUB, 16'h0004, 16'h0005);
        check("sub",       bus.alu_out,       16'hFFFF);
        check("sub_zero",  bus.alu_zero_flag, 1'b0);
`ifdef MIPS_CPU_OVERFLOW_EN
        check("sub_ovf",   bus.alu_overflow,  1'b0);
`endif
        alu_op(ALU_AND, 16'h0004, 16'h0005);
        check("and",       bus.alu_out,       16'h0004);
        alu_op(ALU_OR,  16'h0004, 16'h0005);
        check("or",        bus.alu_out,       16'h0005);
        alu_op(ALU_SLT, 16'h0004, 16'h0005);
        check("slt",       bus.alu_out,       16'h0001);
        alu_op(ALU_SLT, 16'hFFFF, 16'h0001);
        check("slt_neg",   bus.alu_out,       16'h0001);
        alu_op(ALU_SLT, 16'h0005, 16'h0004);
        check("slt_ge",    bus.alu_out,       16'h0000);
        check("slt_ge_z",  bus.alu_zero_flag, 1'b1);
        alu_op(ALU_SUB, 16'h0005, 16'h0005);
        check("sub_eq",    bus.alu_out,       16'h0000);
        check("sub_eq_z",  bus.alu_zero_flag, 1'b1);
        alu_op(ALU_OR,  16'hA5A5, 16'h0F0F);
        check("or_pat",    bus.alu_out,       16'hAFAF);
        alu_op(4'b0000, 16'hA5A5, 16'h0F0F);
        check("sel_inv",   bus.alu_out,       16'h0000);
        check("sel_inv_z", bus.alu_zero_flag, 1'b1);
        alu_op(4'b1111, 16'h1234, 16'h1234);
        check("sel_f",     bus.alu_out,       16'h0000);
        alu_op(ALU_ADD, 16'h7FFF, 16'h0001);
        check("add_wrap",  bus.alu_out,       16'h8000);
`ifdef MIPS_CPU_OVERFLOW_EN
        check("add_ovf",   bus.alu_overflow,  1'b1);
`endif
        alu_op(ALU_SUB, 16'h8000, 16'h0001);
        check("sub_wrap",  bus.alu_out,       16'h7FFF);
`ifdef MIPS_CPU_OVERFLOW_EN
        check("sub_ovf2",  bus.alu_overflow,  1'b1);
`endif
        alu_op(ALU_ADD, 16'hFFFF, 16'h0001);
        check("add_carry", bus.alu_out,       16'h0000);
        check("add_c_z",   bus.alu_zero_flag, 1'b1);
`ifdef MIPS_CPU_OVERFLOW_EN
        check("add_c_ovf", bus.alu_overflow,  1'b0);
`endif
        check("gate_pc0",  bus.pc_counter,    16'h0000);
        check("gate_tm0",  bus.timer,         4'd0);

        // PC unit, key_ok=1
        bus.sel    = 4'b0000;
        bus.key_ok = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("pc_idle3",  bus.pc_counter,    16'h0003);
        check("tm_3",      bus.timer,         4'd3);

        bus.load_pc = 1'b1;
        bus.data_in = 16'h0100;
        tick();
        check("pc_load",   bus.pc_counter,    16'h0100);

        bus.load_pc = 1'b0;
        bus.branch  = 1'b1;
        bus.offset  = 16'hFFFE;
        tick();
        check("pc_branch", bus.pc_counter,    16'h00FF);

        bus.offset  = 16'h0010;
        tick();
        check("pc_br_fwd", bus.pc_counter,    16'h0110);

        bus.load_pc = 1'b1;
        bus.data_in = 16'h0020;
        tick();
        check("pc_ld_br",  bus.pc_counter,    16'h0020);

        bus.branch  = 1'b0;
        bus.data_in = 16'hFFFF;
        tick();
        check("pc_ffff",   bus.pc_counter,    16'hFFFF);
        bus.load_pc = 1'b0;
        tick();
        check("pc_wrap",   bus.pc_counter,    16'h0000);
        check("tm_9",      bus.timer,         4'd9);

        // key_ok=0 for 5 cycles with controls asserted: PC/timer frozen, ALU live
        bus.key_ok  = 1'b0;
        bus.load_pc = 1'b1;
        bus.data_in = 16'h5555;
        bus.sel     = ALU_ADD;
        bus.data_1  = 16'h0001;
        bus.data_2  = 16'h0002;
        for (int i = 0; i < 5; i++) tick();
        check("hold_pc",   bus.pc_counter,    16'h0000);
        check("hold_tm",   bus.timer,         4'd9);
        check("hold_alu",  bus.alu_out,       16'h0003);

        // Mid-operation reset dominates key_ok/load_pc/ALU inputs
        bus.key_ok = 1'b1;
        rst        = 1'b1;
        tick();
        check("rst2_alu",  bus.alu_out,       16'h0000);
        check("rst2_zero", bus.alu_zero_flag, 1'b1);
        check("rst2_pc",   bus.pc_counter,    16'h0000);
        check("rst2_tm",   bus.timer,         4'd0);
        rst         = 1'b0;
        bus.load_pc = 1'b0;
        bus.sel     = 4'b0000;

        // Timer wrap over 16 enabled cycles
        for (int i = 0; i < 15; i++) tick();
        check("tm_15",     bus.timer,         4'd15);
        tick();
        check("tm_wrap",   bus.timer,         4'd0);
        check("pc_16",     bus.pc_counter,    16'h0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
